// File: rtl/mem_dma_if.sv
// Shared single-port RAM bus seen by the DMA engine: arbiter handshake plus
// address/data/write-enable with a registered one-cycle read path.
interface mem_dma_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we;
    logic [DW-1:0] dout;

    modport master (
        output mem_req,
        output addr,
        output din,
        output we,
        input  mem_gnt,
        input  dout
    );

    modport slave (
        input  mem_req,
        input  addr,
        input  din,
        input  we,
        output mem_gnt,
        output dout
    );
endinterface

// File: rtl/mem_dma.sv
// Block copy / fill engine sharing the CPU's synchronous RAM port behind an
// external arbiter; copies run ascending, fills write one word per cycle.
module mem_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [15:0]   len,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    mem_dma_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        FILL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] sp;
    logic [AW-1:0] dp;
    logic [15:0]   cnt;
    logic          md;
    logic [DW-1:0] pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer registers: loaded once per accepted start, stepped per written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            dp  <= '0;
            cnt <= '0;
            md  <= 1'b0;
            pat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sp  <= src;
                        dp  <= dst;
                        cnt <= len;
                        md  <= mode;
                        pat <= pattern;
                    end
                end
                WR: begin
                    sp  <= sp + AW'(1);
                    dp  <= dp + AW'(1);
                    cnt <= cnt - 16'd1;
                end
                FILL: begin
                    dp  <= dp + AW'(1);
                    cnt <= cnt - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs are pure state decodes, so the RAM port sits at zero whenever
    // the engine is not actively addressing memory.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        bus.mem_req = 1'b0;
        bus.addr    = '0;
        bus.din     = '0;
        bus.we      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == 16'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    state_nxt = md ? FILL : RD;
                end
            end
            RD: begin
                bus.mem_req = 1'b1;
                bus.addr    = sp;
                state_nxt   = WR;
            end
            WR: begin
                bus.mem_req = 1'b1;
                bus.addr    = dp;
                bus.din     = bus.dout;
                bus.we      = 1'b1;
                state_nxt   = (cnt == 16'd1) ? DONE : RD;
            end
            FILL: begin
                bus.mem_req = 1'b1;
                bus.addr    = dp;
                bus.din     = pat;
                bus.we      = 1'b1;
                state_nxt   = (cnt == 16'd1) ? DONE : FILL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A write must never appear without the bus being held.
    assert property (@(posedge clk) disable iff (!rst_n) bus.we |-> bus.mem_req);
    assert property (@(posedge clk) disable iff (!rst_n) done |=> !busy);

endmodule

// File: doc/mem_dma.md
# mem_dma

Block-copy/fill initiator that drives the same single-port synchronous RAM interface the CPU uses: `addr`, `din`, `we` out, and `dout` in with one-cycle read latency. It sits beside the core on the memory bus behind an external arbiter. It takes a source, destination, length and mode, then copies `len` words from `src` to `dst`, or fills `len` words at `dst` with `pattern`. Software uses it to preload stacks and arrays without spending core cycles.

## Interface
Parameters:
- `AW`, default 16: address width. Addresses wrap modulo 2^AW.
- `DW`, default 16: data word width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a transfer; sampled only in IDLE.
- `mode`  in  1: 0 = copy, 1 = fill.
- `src`  in  AW: source base address (copy only).
- `dst`  in  AW: destination base address.
- `len`  in  16: word count; 0 is legal.
- `pattern`  in  DW: fill value (fill only).
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle completion pulse.
- `mem_req`  out  1: bus request to the arbiter.
- `mem_gnt`  in  1: bus grant from the arbiter.
- `addr`  out  AW: RAM address.
- `din`  out  DW: RAM write data.
- `we`  out  1: RAM write enable.
- `dout`  in  DW: RAM read data, valid the cycle after `addr` is presented.

## Operation
- States: IDLE, REQ, RD, WR, FILL, DONE. Outputs are decoded from the state and internal registers.
- IDLE:
  - On `start`=1, latch `src`, `dst`, `len`, `mode` and `pattern` into `sp`, `dp`, `cnt`, `md`, `pat`.
  - If `len`==0, go to DONE; otherwise go to REQ.
  - Inputs are ignored in all other states; `start` while busy is dropped with no queuing.
- REQ: `mem_req`=1 with the bus undriven. Stay while `mem_gnt`=0. On `mem_gnt`=1, go to RD (`md`=0) or FILL (`md`=1).
- RD: `addr`=`sp`, `we`=0, then go to WR.
- WR:
  - `addr`=`dp`, `din`=`dout`, `we`=1.
  - Update `sp`+=1, `dp`+=1, `cnt`-=1.
  - Go to DONE if `cnt`==1 on entry, else back to RD.
- FILL:
  - `addr`=`dp`, `din`=`pat`, `we`=1.
  - Update `dp`+=1, `cnt`-=1.
  - Go to DONE if `cnt`==1 on entry, else stay in FILL.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `mem_req`=1 in REQ, RD, WR and FILL.
- `busy`=1 in every state except IDLE.
- When not driving the bus, `addr`=0, `din`=0, `we`=0.
- Arbiter contract: once granted, `mem_gnt` stays high until `mem_req` falls. `mem_dma` does not re-check `mem_gnt` after REQ.
- Addresses increment modulo 2^AW, so 0xFFFF+1 = 0x0000. `cnt` never underflows because `len`==0 bypasses REQ.
- Copies always run ascending. With overlapping ranges where `dst` lies in (`src`, `src`+`len`), already-written words are re-read. This forward propagation is the defined behaviour.

## Timing
- Reset (`rst_n`=0), effective immediately and asynchronously:
  - state = IDLE.
  - `busy`, `done`, `mem_req`, `we` = 0.
  - `addr`, `din` = 0.
  - `sp`, `dp`, `cnt`, `md`, `pat` = 0.
- Reset mid-transfer aborts at once. Words already written stay written; no partial word is written.
- Let `start` be sampled at edge 0, with `mem_gnt` already high:
  - Cycle 1 is REQ.
  - Copy: RD/WR pairs occupy cycles 2 through 1+2·`len`; DONE is cycle 2+2·`len`.
  - Fill: one write per cycle over cycles 2 through 1+`len`; DONE is cycle 2+`len`.
- Each cycle `mem_gnt` stays low in REQ adds one cycle of latency.
- `len`==0: DONE in cycle 1, `busy` high for that one cycle, `mem_req` and `we` never asserted.
- A new `start` is accepted in the IDLE cycle right after DONE, so back-to-back transfers are spaced by one idle cycle minimum.
- The RAM captures `din`/`we` at the end of the WR/FILL cycle. `dout` used in WR is the RAM's registered output from the preceding RD cycle.

## Test plan
- Copy, basic: M[0x20..0x22]=3,4,5; `src`=0x0020, `dst`=0x0040, `len`=3, `mode`=0, `mem_gnt`=1.
  - Required: M[0x40..0x42]=3,4,5.
  - Required: `we` high exactly 3 cycles (3, 5, 7); `done` pulse in cycle 8; `busy` high cycles 1–8.
- Fill with wrap: `dst`=0xFFFE, `len`=4, `pattern`=0xA5A5, `mode`=1.
  - Required: M[0xFFFE], M[0xFFFF], M[0x0000], M[0x0001] = 0xA5A5, written on consecutive cycles 2–5.
  - Required: `done` in cycle 6; M[0x0002] untouched.
- Zero length: `len`=0.
  - Required: `done` and `busy` high in cycle 1 only; `mem_req` and `we` never asserted; IDLE in cycle 2.
- Grant stall: `mem_gnt`=0 for 5 cycles after `start`, then 1; copy of `len`=1.
  - Required: REQ held with `we`=0 throughout the stall; the single write happens 2 cycles after the grant; `done` follows.
- Reset and ignored start:
  - Assert `rst_n`=0 in the RD cycle of word 2 of a `len`=3 copy. Required: all outputs 0 immediately; only word 1 written; a fresh copy after release completes normally.
  - Pulse `start` while busy. Required: no effect.
- Overlap: M[0x10]=7, M[0x11..0x13]=0; `src`=0x10, `dst`=0x11, `len`=3.
  - Required: M[0x11..0x13]=7,7,7 (forward propagation).
